// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared widths and helpers for the RAM port arbiter
package ram_port_arbiter_pkg;

  localparam int AXI_AW = 32;
  localparam int AXI_DW = 32;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arb_id_fifo.sv
// rtl/ram_arb_id_fifo.sv - in-order FIFO of issuing host ids for in-flight RAM transactions
module ram_arb_id_fifo
  import ram_port_arbiter_pkg::*;
#(
  parameter int Depth   = 2,
  parameter int IdWidth = 1,
  localparam int PtrW   = clog2_min1(Depth),
  localparam int CntW   = $clog2(Depth + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [IdWidth-1:0] push_id_i,
  input  logic               pop_i,
  output logic [IdWidth-1:0] head_o,
  output logic [CntW-1:0]    count_o
);

  logic [IdWidth-1:0] mem_q [Depth];
  logic [IdWidth-1:0] mem_d [Depth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Push while full is legal with a pop: the head is read before the slot is overwritten.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && (count_q == CntW'(Depth))));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && (count_q == '0)));
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one req/gnt/rvalid SRAM port between hosts
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int AddrWidth      = AXI_AW,
  parameter int DataWidth      = AXI_DW,
  parameter int MaxOutstanding = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NrHosts-1:0]               host_req_i,
  output logic [NrHosts-1:0]               host_gnt_o,
  input  logic [NrHosts-1:0]               host_we_i,
  input  logic [NrHosts*(DataWidth/8)-1:0] host_be_i,
  input  logic [NrHosts*AddrWidth-1:0]     host_addr_i,
  input  logic [NrHosts*DataWidth-1:0]     host_wdata_i,
  output logic [NrHosts-1:0]               host_rvalid_o,
  output logic [DataWidth-1:0]             host_rdata_o,
  output logic                             host_err_o,
  output logic                             dev_req_o,
  input  logic                             dev_gnt_i,
  output logic                             dev_we_o,
  output logic [DataWidth/8-1:0]           dev_be_o,
  output logic [AddrWidth-1:0]             dev_addr_o,
  output logic [DataWidth-1:0]             dev_wdata_o,
  input  logic                             dev_rvalid_i,
  input  logic [DataWidth-1:0]             dev_rdata_i,
  input  logic                             dev_err_i,
  output logic                             unexp_rsp_o
);

  localparam int IdW  = clog2_min1(NrHosts);
  localparam int BeW  = DataWidth / 8;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  lock_id_q, lock_id_d;
  logic            lock_vld_q, lock_vld_d;
  logic [IdW-1:0]  winner, head_id;
  logic [IdW:0]    idx_ext;
  logic            found, space, accept, pop;
  logic [CntW-1:0] count;

  // A stalled request keeps its winner so the RAM sees stable fields until accepted.
  always_comb begin
    winner  = rr_ptr_q;
    found   = 1'b0;
    idx_ext = '0;
    if (lock_vld_q) begin
      winner = lock_id_q;
    end else begin
      for (int k = 0; k < NrHosts; k++) begin
        idx_ext = {1'b0, rr_ptr_q} + (IdW+1)'(k);
        if (idx_ext >= (IdW+1)'(NrHosts)) begin
          idx_ext = idx_ext - (IdW+1)'(NrHosts);
        end
        if (!found && host_req_i[idx_ext[IdW-1:0]]) begin
          winner = idx_ext[IdW-1:0];
          found  = 1'b1;
        end
      end
    end
  end

  // A response in the same cycle frees a slot, so a full queue can still accept.
  always_comb begin
    space       = (count < CntW'(MaxOutstanding)) | dev_rvalid_i;
    dev_req_o   = (|host_req_i) & space;
    accept      = dev_req_o & dev_gnt_i;
    pop         = dev_rvalid_i & (count != '0);
    unexp_rsp_o = dev_rvalid_i & (count == '0);

    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_addr_o  = '0;
    dev_wdata_o = '0;
    if (dev_req_o) begin
      dev_we_o    = host_we_i[winner];
      dev_be_o    = host_be_i[winner*BeW +: BeW];
      dev_addr_o  = host_addr_i[winner*AddrWidth +: AddrWidth];
      dev_wdata_o = host_wdata_i[winner*DataWidth +: DataWidth];
    end

    host_gnt_o = '0;
    if (accept) begin
      host_gnt_o[winner] = 1'b1;
    end
    host_rvalid_o = '0;
    if (pop) begin
      host_rvalid_o[head_id] = 1'b1;
    end
    host_rdata_o = dev_rdata_i;
    host_err_o   = dev_err_i & pop;

    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (accept) begin
      rr_ptr_d   = (winner == IdW'(NrHosts - 1)) ? '0 : winner + IdW'(1);
      lock_vld_d = 1'b0;
    end else if (dev_req_o) begin
      lock_vld_d = 1'b1;
      lock_id_d  = winner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end

  ram_arb_id_fifo #(
    .Depth   (MaxOutstanding),
    .IdWidth (IdW)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (accept),
    .push_id_i (winner),
    .pop_i     (pop),
    .head_o    (head_id),
    .count_o   (count)
  );

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(host_gnt_o));
  a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(host_rvalid_o));
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count <= CntW'(MaxOutstanding));
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  localparam logic [31:0] A0 = 32'h0010_0010;
  localparam logic [31:0] A1 = 32'h0020_0020;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [1:0]  host_req_i, host_gnt_o, host_we_i, host_rvalid_o;
  logic [7:0]  host_be_i;
  logic [63:0] host_addr_i, host_wdata_i;
  logic [31:0] host_rdata_o;
  logic        host_err_o, dev_req_o, dev_gnt_i, dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_addr_o, dev_wdata_o, dev_rdata_i;
  logic        dev_rvalid_i, dev_err_i, unexp_rsp_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NrHosts(2), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_we_o(dev_we_o), .dev_be_o(dev_be_o),
    .dev_addr_o(dev_addr_o), .dev_wdata_o(dev_wdata_o), .dev_rvalid_i(dev_rvalid_i),
    .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i), .unexp_rsp_o(unexp_rsp_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic err);
    host_req_i   = req;
    dev_gnt_i    = gnt;
    dev_rvalid_i = rv;
    dev_rdata_i  = rd;
    dev_err_i    = err;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    host_we_i    = 2'b10;
    host_be_i    = {4'hC, 4'hF};
    host_addr_i  = {A1, A0};
    host_wdata_i = {32'h1111_1111, 32'h0000_0000};
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    sample();
    check("rst_gnt", host_gnt_o, 2'b00);
    check("rst_rvalid", host_rvalid_o, 2'b00);
    check("rst_dev_req", dev_req_o, 1'b0);
    check("rst_unexp", unexp_rsp_o, 1'b0);
    tick();
    rst_ni = 1'b1;

    // single read from host0
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t1_dev_req", dev_req_o, 1'b1);
    check("t1_addr", dev_addr_o, A0);
    check("t1_we", dev_we_o, 1'b0);
    check("t1_be", dev_be_o, 4'hF);
    check("t1_gnt", host_gnt_o, 2'b01);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    sample();
    check("t1_rvalid", host_rvalid_o, 2'b01);
    check("t1_rdata", host_rdata_o, 32'hDEAD_BEEF);
    check("t1_unexp", unexp_rsp_o, 1'b0);
    tick();

    // rr_ptr is now 1: host0 stalls and must stay locked even after host1 joins
    for (int c = 0; c < 3; c++) begin
      drive((c == 0) ? 2'b01 : 2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
      sample();
      check("t3_stall_addr", dev_addr_o, A0);
      check("t3_stall_gnt", host_gnt_o, 2'b00);
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t3_gnt0", host_gnt_o, 2'b01);
    check("t3_addr0", dev_addr_o, A0);
    tick();
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t3_gnt1", host_gnt_o, 2'b10);
    check("t3_addr1", dev_addr_o, A1);
    check("t3_we1", dev_we_o, 1'b1);
    check("t3_be1", dev_be_o, 4'hC);
    check("t3_wdata1", dev_wdata_o, 32'h1111_1111);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h3333_0000, 1'b0);
    sample();
    check("t3_rsp0", host_rvalid_o, 2'b01);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h3333_0001, 1'b0);
    sample();
    check("t3_rsp1", host_rvalid_o, 2'b10);
    tick();

    // both hosts streaming with a 1-cycle RAM
    for (int k = 0; k < 5; k++) begin
      logic [31:0] rd;
      rd = 32'hA000_0000 + 32'(k);
      drive((k < 4) ? 2'b11 : 2'b00, 1'b1, k > 0, rd, 1'b0);
      sample();
      if (k < 4) check("t2_gnt", host_gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check("t2_rvalid", host_rvalid_o, ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
        check("t2_rdata", host_rdata_o, rd);
      end
      tick();
    end

    // fill both slots, then a same-cycle response lets a new request in
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t4_gnt_a", host_gnt_o, 2'b01);
    tick();
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t4_gnt_b", host_gnt_o, 2'b10);
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t4_full_req", dev_req_o, 1'b0);
    check("t4_full_gnt", host_gnt_o, 2'b00);
    check("t4_full_addr", dev_addr_o, 32'h0);
    tick();
    drive(2'b11, 1'b1, 1'b1, 32'h4444_0000, 1'b0);
    sample();
    check("t4_pop_gnt", host_gnt_o, 2'b01);
    check("t4_pop_rvalid", host_rvalid_o, 2'b01);
    tick();
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t4_still_full", dev_req_o, 1'b0);
    tick();
    drive(2'b10, 1'b1, 1'b1, 32'h4444_0001, 1'b0);
    sample();
    check("t4_gnt_c", host_gnt_o, 2'b10);
    check("t4_rvalid_c", host_rvalid_o, 2'b10);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h4444_0002, 1'b1);
    sample();
    check("t4_drain0", host_rvalid_o, 2'b01);
    check("t4_err", host_err_o, 1'b1);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h4444_0003, 1'b0);
    sample();
    check("t4_drain1", host_rvalid_o, 2'b10);
    tick();

    // response with nothing in flight
    drive(2'b00, 1'b0, 1'b1, 32'h5555_5555, 1'b0);
    sample();
    check("t5_unexp", unexp_rsp_o, 1'b1);
    check("t5_rvalid", host_rvalid_o, 2'b00);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    sample();
    check("t5_unexp_clr", unexp_rsp_o, 1'b0);
    tick();

    // reset with two in flight and rr_ptr at 1
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t6_gnt_a", host_gnt_o, 2'b10);
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t6_gnt_b", host_gnt_o, 2'b01);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_ni = 1'b0;
    sample();
    check("t6_rst_gnt", host_gnt_o, 2'b00);
    check("t6_rst_rvalid", host_rvalid_o, 2'b00);
    check("t6_rst_req", dev_req_o, 1'b0);
    check("t6_rst_unexp", unexp_rsp_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    drive(2'b00, 1'b0, 1'b1, 32'h6666_6666, 1'b0);
    sample();
    check("t6_unexp", unexp_rsp_o, 1'b1);
    check("t6_rvalid", host_rvalid_o, 2'b00);
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    sample();
    check("t6_rr0_gnt", host_gnt_o, 2'b01);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
